left_shift_unit: RTL and testbench
==================================

# left_shift_unit

Sequential left-shift unit for the DSP datapath. It shifts an operand left by 0–7 positions, one bit per clock, in either logical or rotate mode. It reports a carry (the last bit out) and a sticky overflow, and handshakes with the controller through Start, Busy and Done. It is the left-direction counterpart to the datapath's combinational logical right shift, and it sits beside it as an ALU operand path.

## Interface
- WIDTH, 8, operand and result width in bits.
- AMT_W, 3, shift-amount width; the maximum shift is 2^AMT_W − 1 and must be less than WIDTH.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only when Busy=0.
- In1  in  WIDTH  operand; captured on an accepted Start.
- Amt  in  AMT_W  shift count; captured on an accepted Start.
- Rotate  in  1  mode; captured on an accepted Start. 0 selects logical shift (zero fill), 1 selects rotate (bit WIDTH−1 refills bit 0).
- Out  out  WIDTH  result register; holds its value until the next accepted Start.
- Carry  out  1  last bit shifted out of bit WIDTH−1; 0 when Amt=0.
- Ovf  out  1  in logical mode, set if any 1 was shifted out; always 0 in rotate mode.
- Busy  out  1  high in state SHIFT.
- Done  out  1  one-cycle pulse; Out, Carry and Ovf are final while it is high.

## Operation
- States: IDLE, SHIFT, DONE.
- Busy is low in IDLE and DONE, so Start is accepted in either state. This allows back-to-back operations.
- Accepted Start with Amt=0: Out←In1, Carry←0, Ovf←0, state goes to DONE.
- Accepted Start with Amt=N>0: Out←In1, Carry←0, Ovf←0, cnt←N, state goes to SHIFT.
- On each SHIFT clock:
  - Carry←Out[WIDTH−1].
  - Out←{Out[WIDTH−2:0], Rotate ? Out[WIDTH−1] : 0}.
  - Ovf←Ovf | (~Rotate & Out[WIDTH−1]).
  - cnt←cnt−1.
  - When cnt=1 before the decrement, state goes to DONE.
- Start is ignored in SHIFT. Captured operands are not disturbed, and the request is not queued.
- DONE with no Start goes to IDLE on the next clock.
- reset in any state, including mid-shift:
  - state←IDLE, cnt←0.
  - Out←0, Carry←0, Ovf←0, Busy=0, Done=0.
  - Any in-flight operation is discarded, with no Done.
- reset takes priority over a simultaneous Start.

## Timing
- Let E0 be the clock edge that accepts Start, and Ek the k-th edge after it.
- The state register is updated at E0; In1, Amt and Rotate need only be valid at E0.
- Done is high in exactly the cycle following edge E_N, where N=Amt.
  - For Amt=0 that is the cycle after E0, i.e. a 1-cycle latency.
  - For Amt=7 it is the cycle after E7.
- Busy is high from the cycle after E0 to the cycle after E_{N−1}, inclusive. Busy is never high when Amt=0.
- Done and Busy are never high together.
- Out changes only at accepted-Start edges and SHIFT edges. It is stable during Done and holds afterwards.
- Throughput: one result per N+1 cycles with back-to-back Start in DONE. With Start delayed until IDLE it is one per N+2 cycles.

## Structure
- Shared defines include file: state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), and the default WIDTH and AMT_W.
- One natural sub-module: shift_step. It is the combinational single-position left shift/rotate, with carry-out, and it mirrors the existing right shifter.
- The top level holds the FSM, the counter, and the Out/Carry/Ovf registers.
- Done and Busy are decoded from the state register, so they are glitch-free registered outputs.

## Test plan
- Logical shift: In1=0x96, Amt=3, Rotate=0 → Out=0xB0, Carry=0, Ovf=1; Done in the cycle after E3; Busy high for 3 cycles.
- Rotate: In1=0x96, Amt=3, Rotate=1 → Out=0xB4, Carry=0, Ovf=0.
- Zero shift: In1=0x96, Amt=0 → Out=0x96, Carry=0, Ovf=0; Done in the cycle after E0; Busy never high.
- Maximum shift and overflow boundary:
  - In1=0x01, Amt=7, logical → Out=0x80, Carry=0, Ovf=0.
  - In1=0x03, Amt=7 → Out=0x80, Carry=1, Ovf=1.
- Start while busy: start In1=0x0F, Amt=5; pulse Start with In1=0xFF, Amt=1 at E2 → the second request is ignored; Out=0xE0, Carry=1, Ovf=1 at E5.
- Reset mid-operation: assert reset at E2 of an Amt=6 shift → all outputs 0 next cycle; no Done; a new Start is accepted immediately after reset deasserts.

Source files
------------

// File: rtl/left_shift_unit_pkg.sv
// Shared constants for the sequential left-shift unit: default widths and
// the controller state encodings.
package left_shift_unit_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;

  // State encodings kept as plain constants so older tools can share them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/left_shift_unit_shift_step.sv
// Combinational single-position left shift or rotate with carry-out.
// Left-direction twin of the datapath's right shifter.
module left_shift_unit_shift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             rotate,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // Move every bit up one place; the vacated LSB is zero or the old MSB
  always_comb begin
    result = {data[WIDTH-2:0], rotate ? data[WIDTH-1] : 1'b0};
    carry  = data[WIDTH-1];
  end

endmodule

// File: rtl/left_shift_unit.sv
// Sequential left-shift unit: shifts the captured operand one position per
// clock, tracking the last bit out (Carry) and a sticky logical overflow.
module left_shift_unit
  import left_shift_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] In1,
  input  logic [AMT_W-1:0] Amt,
  input  logic             Rotate,
  output logic [WIDTH-1:0] Out,
  output logic             Carry,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  logic [1:0]       state;
  logic [AMT_W-1:0] cnt;
  logic             rot_mode;
  logic [WIDTH-1:0] step_result;
  logic             step_carry;
  logic             accept;

  left_shift_unit_shift_step #(.WIDTH(WIDTH)) u_step (
    .data   (Out),
    .rotate (rot_mode),
    .result (step_result),
    .carry  (step_carry)
  );

  // Handshake outputs come straight from the state register
  assign Busy   = (state == ST_SHIFT);
  assign Done   = (state == ST_DONE);
  assign accept = Start && !Busy;

  // Controller, counter and result registers; reset discards any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rot_mode <= 1'b0;
      Out      <= '0;
      Carry    <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            Out      <= In1;
            Carry    <= 1'b0;
            Ovf      <= 1'b0;
            cnt      <= Amt;
            rot_mode <= Rotate;
            state    <= (Amt == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          Out   <= step_result;
          Carry <= step_carry;
          Ovf   <= Ovf | (~rot_mode & Out[WIDTH-1]);
          cnt   <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_left_shift_unit.sv
// Directed self-checking bench for left_shift_unit.
module tb_left_shift_unit;

  logic       clk;
  logic       reset;
  logic       Start;
  logic [7:0] In1;
  logic [2:0] Amt;
  logic       Rotate;
  logic [7:0] Out;
  logic       Carry;
  logic       Ovf;
  logic       Busy;
  logic       Done;

  int n_checks;
  int n_fail;

  left_shift_unit dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .In1    (In1),
    .Amt    (Amt),
    .Rotate (Rotate),
    .Out    (Out),
    .Carry  (Carry),
    .Ovf    (Ovf),
    .Busy   (Busy),
    .Done   (Done)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request before the next rising edge (E0) and leave 1 ns after
  task automatic apply_stimulus(input logic [7:0] a, input logic [2:0] n,
                                input logic r);
    @(negedge clk);
    Start  = 1'b1;
    In1    = a;
    Amt    = n;
    Rotate = r;
    @(posedge clk);
    #1;
    Start  = 1'b0;
    In1    = ~a;
    Amt    = ~n;
    Rotate = ~r;
  endtask

  // Full operation: Busy for n cycles, then Done with final results
  task automatic run_op(input string tag, input logic [7:0] a,
                        input logic [2:0] n, input logic r,
                        input logic [7:0] eo, input logic ec, input logic ev);
    apply_stimulus(a, n, r);
    for (int k = 0; k < int'(n); k++) begin
      check_output({tag, "_busy"}, 32'(Busy), 32'd1);
      check_output({tag, "_nodone"}, 32'(Done), 32'd0);
      @(posedge clk);
      #1;
    end
    check_output({tag, "_done"}, 32'(Done), 32'd1);
    check_output({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
    check_output({tag, "_out"}, 32'(Out), 32'(eo));
    check_output({tag, "_carry"}, 32'(Carry), 32'(ec));
    check_output({tag, "_ovf"}, 32'(Ovf), 32'(ev));
    @(posedge clk);
    #1;
    check_output({tag, "_done_pulse"}, 32'(Done), 32'd0);
    check_output({tag, "_out_hold"}, 32'(Out), 32'(eo));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    Start    = 1'b0;
    In1      = 8'h00;
    Amt      = 3'd0;
    Rotate   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_out", 32'(Out), 32'h0);
    check_output("rst_carry", 32'(Carry), 32'h0);
    check_output("rst_ovf", 32'(Ovf), 32'h0);
    check_output("rst_busy", 32'(Busy), 32'h0);
    check_output("rst_done", 32'(Done), 32'h0);
    reset = 1'b0;

    run_op("logic3", 8'h96, 3'd3, 1'b0, 8'hB0, 1'b0, 1'b1);
    run_op("rot3",   8'h96, 3'd3, 1'b1, 8'hB4, 1'b0, 1'b0);
    run_op("zero",   8'h96, 3'd0, 1'b0, 8'h96, 1'b0, 1'b0);
    run_op("max01",  8'h01, 3'd7, 1'b0, 8'h80, 1'b0, 1'b0);
    run_op("max03",  8'h03, 3'd7, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("rot7",   8'h81, 3'd7, 1'b1, 8'hC0, 1'b0, 1'b0);

    // Start while busy: second request at E2 must be ignored
    apply_stimulus(8'h0F, 3'd5, 1'b0);
    @(posedge clk);
    #1;
    Start = 1'b1;
    In1   = 8'hFF;
    Amt   = 3'd1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    check_output("busy_ign_busy", 32'(Busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_output("busy_ign_done", 32'(Done), 32'd1);
    check_output("busy_ign_out", 32'(Out), 32'hE0);
    check_output("busy_ign_carry", 32'(Carry), 32'd1);
    check_output("busy_ign_ovf", 32'(Ovf), 32'd1);
    @(posedge clk);
    #1;
    check_output("busy_ign_idle", 32'(Done | Busy), 32'd0);

    // Back-to-back: a new Start during Done is accepted at once
    apply_stimulus(8'h81, 3'd1, 1'b1);
    check_output("b2b_busy1", 32'(Busy), 32'd1);
    Start  = 1'b1;
    In1    = 8'h40;
    Amt    = 3'd1;
    Rotate = 1'b0;
    @(posedge clk);
    #1;
    check_output("b2b_done1", 32'(Done), 32'd1);
    check_output("b2b_out1", 32'(Out), 32'h03);
    check_output("b2b_carry1", 32'(Carry), 32'd1);
    @(posedge clk);
    #1;
    Start = 1'b0;
    check_output("b2b_busy2", 32'(Busy), 32'd1);
    check_output("b2b_out_load", 32'(Out), 32'h40);
    @(posedge clk);
    #1;
    check_output("b2b_done2", 32'(Done), 32'd1);
    check_output("b2b_out2", 32'(Out), 32'h80);
    check_output("b2b_ovf2", 32'(Ovf), 32'd0);
    @(posedge clk);
    #1;

    // Reset at E2 of an Amt=6 shift
    apply_stimulus(8'h55, 3'd6, 1'b0);
    @(posedge clk);
    #1;
    check_output("rstmid_pre_out", 32'(Out), 32'hAA);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("rstmid_out", 32'(Out), 32'h0);
    check_output("rstmid_carry", 32'(Carry), 32'h0);
    check_output("rstmid_ovf", 32'(Ovf), 32'h0);
    check_output("rstmid_busy", 32'(Busy), 32'h0);
    check_output("rstmid_done", 32'(Done), 32'h0);
    run_op("after_rst", 8'hC1, 3'd2, 1'b0, 8'h04, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
